ysyx_ifu_axi_rd: RTL

//  Instruction-fetch read bridge upstream of the IFU. It turns the IFU's level-held

---
 rtl/ysyx_ifu_axi_rd.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_ifu_axi_rd.sv
// ysyx_ifu_axi_rd
// Instruction-fetch read bridge. Converts the IFU's level-held fetch request into
// one AXI4-Lite read at a time and returns a single-cycle response pulse.
// Misaligned fetches are answered locally with an error. A pipeline flush abandons
// the fetch, although any bus transaction already started is still retired. A
// timeout watchdog forces an error response when the slave stalls.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   ifu_araddr, ifu_arvalid  fetch request from the IFU (level-held)
//   flush                    pipeline redirect
//   ifu_rdata/rvalid/rerr    fetch response pulse back to the IFU
//   m_ar*, m_r*              AXI4-Lite read address / read data channels
//
// States
//   IDLE     | waiting for a fetch request
//   AR       | address presented, waiting for m_arready
//   R        | waiting for the read beat
//   RESP     | ifu_rvalid pulse cycle
//   HOLD     | response given; IFU still holds the same request
//   DRAIN_AR | abandoned fetch, address still owed to the bus
//   DRAIN_R  | abandoned fetch, read beat still owed by the bus
module ysyx_ifu_axi_rd #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  input  logic              flush,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_rerr,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_RESP, S_HOLD, S_DRAIN_AR, S_DRAIN_R
  } state_t;

  localparam logic [8:0] TO_VAL = 9'(TIMEOUT);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              err_q, err_nxt;
  logic              resp_q, resp_nxt;
  logic              timeout;

  // The counter holds the number of AR/R cycles already completed, so the
  // current cycle is the TIMEOUT-th one when cnt+1 reaches TIMEOUT.
  assign cnt_inc = ({1'b0, cnt} >= TO_VAL) ? cnt : cnt + 8'd1;
  assign timeout = (TIMEOUT != 0) && (({1'b0, cnt} + 9'd1) == TO_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      resp_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
      resp_q <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    err_nxt   = err_q;
    resp_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ifu_arvalid && !flush) begin
          addr_nxt = ifu_araddr;
          if (ifu_araddr[1:0] != 2'b00) begin
            state_nxt = S_RESP;
            resp_nxt  = 1'b1;
            err_nxt   = 1'b1;
            data_nxt  = '0;
          end else begin
            state_nxt = S_AR;
            cnt_nxt   = '0;
          end
        end
      end
      S_AR: begin
        cnt_nxt = cnt_inc;
        if (flush) begin
          state_nxt = m_arready ? S_DRAIN_R : S_DRAIN_AR;
        end else if (timeout) begin
          // forced error pulse is issued while the bus is retired
          state_nxt = m_arready ? S_DRAIN_R : S_DRAIN_AR;
          resp_nxt  = 1'b1;
          err_nxt   = 1'b1;
          data_nxt  = '0;
        end else if (m_arready) begin
          state_nxt = S_R;
        end
      end
      S_R: begin
        cnt_nxt = cnt_inc;
        if (flush) begin
          state_nxt = m_rvalid ? S_IDLE : S_DRAIN_R;
        end else if (m_rvalid) begin
          // real data takes priority over a coincident timeout
          state_nxt = S_RESP;
          resp_nxt  = 1'b1;
          err_nxt   = (m_rresp != 2'b00);
          data_nxt  = m_rdata;
        end else if (timeout) begin
          state_nxt = S_DRAIN_R;
          resp_nxt  = 1'b1;
          err_nxt   = 1'b1;
          data_nxt  = '0;
        end
      end
      S_RESP: begin
        state_nxt = flush ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (flush || !ifu_arvalid || (ifu_araddr != addr_q)) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN_AR: begin
        if (m_arready) state_nxt = S_DRAIN_R;
      end
      S_DRAIN_R: begin
        if (m_rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A flush in the pulse cycle suppresses the response.
  assign ifu_rvalid = resp_q & ~flush;
  assign ifu_rerr   = err_q;
  assign ifu_rdata  = data_q;
  assign m_araddr   = addr_q;
  assign m_arvalid  = (state == S_AR) || (state == S_DRAIN_AR);
  assign m_rready   = (state == S_R) || (state == S_DRAIN_R);

endmodule
